acl_poll_core: RTL and testbench

ACL_POLL_CORE -- requirements
Module: acl_poll_core

---
 rtl/acl_pkg.sv | 56 +++++
 rtl/acl_spi_shifter.sv | 64 ++++++
 rtl/acl_poll_core.sv | 168 ++++++++++++++++
 tb/tb_acl_poll_core.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/acl_pkg.sv
// Shared types and constants for the ADXL362 polling core: FSM states, SPI
// command/register bytes and the MMIO register offsets.
package acl_pkg;

  typedef enum logic [3:0] {
    IDLE,
    WAIT,
    SETUP,
    SHIFT,
    HOLD,
    UPDATE,
    INIT_SETUP,
    INIT_SHIFT,
    INIT_HOLD
  } state_t;

  localparam logic [7:0] CMD_READ          = 8'h0B;
  localparam logic [7:0] CMD_WRITE         = 8'h0A;
  localparam logic [7:0] REG_XDATA_L       = 8'h0E;
  localparam logic [7:0] REG_POWER_CTL     = 8'h2D;
  localparam logic [7:0] POWER_CTL_MEASURE = 8'h02;

  localparam logic [2:0] READ_LAST_BYTE = 3'd7;
  localparam logic [2:0] INIT_LAST_BYTE = 3'd2;

  localparam logic [4:0] ADDR_CTRL  = 5'd0;
  localparam logic [4:0] ADDR_X     = 5'd1;
  localparam logic [4:0] ADDR_Y     = 5'd2;
  localparam logic [4:0] ADDR_Z     = 5'd3;
  localparam logic [4:0] ADDR_COUNT = 5'd4;
  localparam logic [4:0] ADDR_CLEAR = 5'd5;

  // Byte idx of either the init write frame or the burst read frame.
  function automatic logic [7:0] frame_byte(input logic init, input logic [2:0] idx);
    frame_byte = 8'h00;
    if (init) begin
      case (idx)
        3'd0:    frame_byte = CMD_WRITE;
        3'd1:    frame_byte = REG_POWER_CTL;
        3'd2:    frame_byte = POWER_CTL_MEASURE;
        default: frame_byte = 8'h00;
      endcase
    end else begin
      case (idx)
        3'd0:    frame_byte = CMD_READ;
        3'd1:    frame_byte = REG_XDATA_L;
        default: frame_byte = 8'h00;
      endcase
    end
  endfunction

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/acl_spi_shifter.sv
// Mode-0 SPI byte shifter with SCLK divider. A start on the done cycle chains
// the next byte without stretching SCLK.
module acl_spi_shifter #(
  parameter int CLK_DIV = 50
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] tx,
  input  logic       miso,
  output logic       done,
  output logic [7:0] rx,
  output logic       sclk,
  output logic       mosi
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic          active;
  logic [DW-1:0] div_cnt;
  logic [2:0]    bit_cnt;
  logic [6:0]    tx_sh;
  logic          phase_end;

  assign phase_end = active && (div_cnt == DW'(CLK_DIV - 1));
  assign done      = phase_end && sclk && (bit_cnt == 3'd7);

  always_ff @(posedge clk) begin
    if (reset) begin
      active  <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
      tx_sh   <= '0;
      rx      <= '0;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
    end else if (start && (!active || done)) begin
      active  <= 1'b1;
      div_cnt <= '0;
      bit_cnt <= '0;
      tx_sh   <= tx[6:0];
      sclk    <= 1'b0;
      mosi    <= tx[7];
    end else if (phase_end) begin
      div_cnt <= '0;
      if (!sclk) begin
        sclk <= 1'b1;
        rx   <= {rx[6:0], miso};
      end else begin
        sclk <= 1'b0;
        if (bit_cnt == 3'd7) begin
          active <= 1'b0;
        end else begin
          bit_cnt <= bit_cnt + 3'd1;
          mosi    <= tx_sh[6];
          tx_sh   <= {tx_sh[5:0], 1'b0};
        end
      end
    end else if (active) begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

endmodule

// File: rtl/acl_poll_core.sv
// Periodic ADXL362 X/Y/Z poller behind a small MMIO slot. Define ACL_INIT_EN
// to send a one-shot POWER_CTL=measure write on the first enable after reset.
module acl_poll_core #(
  parameter int CLK_DIV     = 50,
  parameter int POLL_CYCLES = 100_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        read,
  input  logic        write,
  input  logic [4:0]  addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        spi_sclk,
  output logic        spi_mosi,
  output logic        spi_ss_n,
  input  logic        spi_miso
);

  import acl_pkg::*;

  localparam logic [31:0] DIV_LAST  = 32'(CLK_DIV - 1);
  localparam logic [31:0] POLL_LAST = 32'(POLL_CYCLES - 1);

  state_t      state, next_state;
  logic        enable, valid, busy, wr_en;
  logic [31:0] x_reg, y_reg, z_reg, frame_count, timer;
  logic [2:0]  byte_idx;
  logic [47:0] rx_data;
  logic        sh_start, sh_done;
  logic [7:0]  sh_tx, sh_rx;
  logic        init_pending;
  logic        unused_bits;

  assign wr_en       = cs && write;
  assign unused_bits = ^{read, wr_data[31:1]};

`ifdef ACL_INIT_EN
  logic init_done;
  always_ff @(posedge clk) begin
    if (reset)                  init_done <= 1'b0;
    else if (state == INIT_HOLD) init_done <= 1'b1;
  end
  assign init_pending = !init_done;
`else
  assign init_pending = 1'b0;
`endif

  acl_spi_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
    .clk   (clk),
    .reset (reset),
    .start (sh_start),
    .tx    (sh_tx),
    .miso  (spi_miso),
    .done  (sh_done),
    .rx    (sh_rx),
    .sclk  (spi_sclk),
    .mosi  (spi_mosi)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:       if (enable) next_state = init_pending ? INIT_SETUP : WAIT;
      WAIT:       if (!enable) next_state = IDLE;
                  else if (timer == POLL_LAST) next_state = SETUP;
      SETUP:      if (timer == DIV_LAST) next_state = SHIFT;
      SHIFT:      if (sh_done && byte_idx == READ_LAST_BYTE) next_state = HOLD;
      HOLD:       if (timer == DIV_LAST) next_state = UPDATE;
      UPDATE:     next_state = enable ? WAIT : IDLE;
      INIT_SETUP: if (timer == DIV_LAST) next_state = INIT_SHIFT;
      INIT_SHIFT: if (sh_done && byte_idx == INIT_LAST_BYTE) next_state = INIT_HOLD;
      INIT_HOLD:  if (timer == DIV_LAST) next_state = enable ? WAIT : IDLE;
      default:    next_state = IDLE;
    endcase
  end

  always_comb begin
    busy     = 1'b0;
    spi_ss_n = 1'b1;
    sh_start = 1'b0;
    sh_tx    = 8'h00;
    case (state)
      SETUP, INIT_SETUP: begin
        busy     = 1'b1;
        spi_ss_n = 1'b0;
        sh_start = (timer == DIV_LAST);
        sh_tx    = frame_byte(state == INIT_SETUP, 3'd0);
      end
      SHIFT: begin
        busy     = 1'b1;
        spi_ss_n = 1'b0;
        sh_start = sh_done && (byte_idx != READ_LAST_BYTE);
        sh_tx    = frame_byte(1'b0, byte_idx + 3'd1);
      end
      INIT_SHIFT: begin
        busy     = 1'b1;
        spi_ss_n = 1'b0;
        sh_start = sh_done && (byte_idx != INIT_LAST_BYTE);
        sh_tx    = frame_byte(1'b1, byte_idx + 3'd1);
      end
      HOLD, INIT_HOLD: begin
        busy     = 1'b1;
        spi_ss_n = 1'b0;
      end
      UPDATE:  busy = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  // One timer serves the poll interval and the SETUP/HOLD guard times.
  always_ff @(posedge clk) begin
    if (reset || next_state != state || state == IDLE) timer <= '0;
    else                                                timer <= timer + 32'd1;
  end

  // Eight pushes into a 6-byte window leave XL..ZH, dropping the two dummy bytes.
  always_ff @(posedge clk) begin
    if (reset) begin
      byte_idx <= '0;
      rx_data  <= '0;
    end else begin
      if (state == SETUP || state == INIT_SETUP) byte_idx <= '0;
      else if (sh_done)                          byte_idx <= byte_idx + 3'd1;
      if (state == SHIFT && sh_done) rx_data <= {sh_rx, rx_data[47:8]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      enable      <= 1'b0;
      valid       <= 1'b0;
      x_reg       <= '0;
      y_reg       <= '0;
      z_reg       <= '0;
      frame_count <= '0;
    end else begin
      if (wr_en && addr == ADDR_CTRL)  enable <= wr_data[0];
      if (wr_en && addr == ADDR_CLEAR) valid  <= 1'b0;
      if (state == UPDATE) begin
        x_reg       <= sext16(rx_data[15:0]);
        y_reg       <= sext16(rx_data[31:16]);
        z_reg       <= sext16(rx_data[47:32]);
        valid       <= 1'b1;
        frame_count <= frame_count + 32'd1;
      end
    end
  end

  always_comb begin
    rd_data = '0;
    case (addr)
      ADDR_CTRL:  rd_data = {30'd0, valid, busy};
      ADDR_X:     rd_data = x_reg;
      ADDR_Y:     rd_data = y_reg;
      ADDR_Z:     rd_data = z_reg;
      ADDR_COUNT: rd_data = frame_count;
      default:    rd_data = '0;
    endcase
  end

endmodule

// File: tb/tb_acl_poll_core.sv
// Directed bench for acl_poll_core with an ADXL362 slave model and a frame
// scoreboard; also covers the ACL_INIT_EN build when that macro is defined.
module tb_acl_poll_core;

  localparam int CLK_DIV     = 2;
  localparam int POLL_CYCLES = 64;

  logic        clk = 1'b0;
  logic        reset, cs, read, write;
  logic [4:0]  addr;
  logic [31:0] wr_data, rd_data;
  logic        spi_sclk, spi_mosi, spi_ss_n;
  logic        spi_miso = 1'b0;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  typedef struct {
    logic [31:0] x, y, z, count, status;
  } frame_exp_t;

  frame_exp_t sb[$];
  logic [7:0] mosi_exp[$];
  int         edge_exp[$];

  logic [63:0] miso_pattern = 64'h0000_3412_F0FF_0180;
  logic [7:0]  mosi_shift = 8'h00;
  int          edge_cnt = 0;
  int          bit_pos = 0;
  logic        in_frame = 1'b0;

  always #5 clk = ~clk;

  acl_poll_core #(.CLK_DIV(CLK_DIV), .POLL_CYCLES(POLL_CYCLES)) dut (
    .clk      (clk),
    .reset    (reset),
    .cs       (cs),
    .read     (read),
    .write    (write),
    .addr     (addr),
    .wr_data  (wr_data),
    .rd_data  (rd_data),
    .spi_sclk (spi_sclk),
    .spi_mosi (spi_mosi),
    .spi_ss_n (spi_ss_n),
    .spi_miso (spi_miso)
  );

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ADXL362 slave: MISO launched at ss_n fall and on each SCLK fall.
  always @(negedge spi_ss_n) begin
    in_frame = 1'b1;
    edge_cnt = 0;
    bit_pos  = 0;
    spi_miso = miso_pattern[63];
    check_output("sclk_at_ss_fall", {31'd0, spi_sclk}, 32'd0);
  end

  always @(posedge spi_ss_n) begin
    if (in_frame && !reset) begin
      check_output("sclk_at_ss_rise", {31'd0, spi_sclk}, 32'd0);
      if (edge_exp.size() > 0) check_output("sclk_edges", edge_cnt, edge_exp.pop_front());
    end
    in_frame = 1'b0;
  end

  always @(negedge spi_sclk) begin
    if (spi_ss_n === 1'b0) begin
      bit_pos++;
      spi_miso = (bit_pos < 64) ? miso_pattern[63 - bit_pos] : 1'b0;
    end
  end

  always @(posedge spi_sclk) begin
    if (spi_ss_n === 1'b0) begin
      mosi_shift = {mosi_shift[6:0], spi_mosi};
      edge_cnt++;
      if (edge_cnt % 8 == 0 && mosi_exp.size() > 0)
        check_output("mosi_byte", {24'd0, mosi_shift}, {24'd0, mosi_exp.pop_front()});
    end
  end

  task automatic apply_stimulus(input logic [4:0] a, input logic [31:0] d);
    addr = a; wr_data = d; cs = 1'b1; write = 1'b1;
    @(posedge clk); #1;
    cs = 1'b0; write = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [4:0] a, input logic [31:0] exp);
    addr = a; cs = 1'b1; read = 1'b1;
    #1;
    check_output(tag, rd_data, exp);
    cs = 1'b0; read = 1'b0;
  endtask

  task automatic wait_ss(input logic level, input string tag);
    int n = 0;
    while (spi_ss_n !== level && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    if (spi_ss_n !== level) check_output(tag, {31'd0, spi_ss_n}, {31'd0, level});
  endtask

  task automatic push_read_frame(input logic [31:0] count);
    frame_exp_t e;
    e.x = 32'h0000_1234; e.y = 32'hFFFF_FFF0; e.z = 32'hFFFF_8001;
    e.count = count; e.status = 32'h2;
    sb.push_back(e);
    mosi_exp.push_back(8'h0B);
    mosi_exp.push_back(8'h0E);
    repeat (6) mosi_exp.push_back(8'h00);
    edge_exp.push_back(64);
  endtask

  task automatic pop_check(input string tag);
    frame_exp_t e;
    if (sb.size() == 0) begin
      check_output({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      read_check({tag, "_x"}, 5'd1, e.x);
      read_check({tag, "_y"}, 5'd2, e.y);
      read_check({tag, "_z"}, 5'd3, e.z);
      read_check({tag, "_count"}, 5'd4, e.count);
      read_check({tag, "_status"}, 5'd0, e.status);
    end
  endtask

`ifdef ACL_INIT_EN
  task automatic run_init_frame(input string tag);
    wait_ss(1'b0, {tag, "_init_start"});
    wait_ss(1'b1, {tag, "_init_end"});
    @(posedge clk); #1;
    read_check({tag, "_init_x"}, 5'd1, 32'd0);
    read_check({tag, "_init_count"}, 5'd4, 32'd0);
  endtask

  task automatic push_init_frame();
    mosi_exp.push_back(8'h0A);
    mosi_exp.push_back(8'h2D);
    mosi_exp.push_back(8'h02);
    edge_exp.push_back(24);
  endtask
`endif

  initial begin
    repeat (20000) @(posedge clk);
    $display("[TB] FAIL watchdog: got no summary, expected finish within 20000 cycles");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int low_cnt;
    reset = 1'b1; cs = 1'b0; read = 1'b0; write = 1'b0; addr = '0; wr_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check_output("rst_ss_n", {31'd0, spi_ss_n}, 32'd1);
    check_output("rst_sclk", {31'd0, spi_sclk}, 32'd0);
    check_output("rst_mosi", {31'd0, spi_mosi}, 32'd0);
    read_check("rst_status", 5'd0, 32'd0);
    read_check("rst_x", 5'd1, 32'd0);
    read_check("rst_count", 5'd4, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // First frame, with valid-clear write and X read landing on UPDATE.
`ifdef ACL_INIT_EN
    push_init_frame();
`endif
    push_read_frame(32'd1);
    apply_stimulus(5'd0, 32'd1);
`ifdef ACL_INIT_EN
    run_init_frame("f1");
`endif
    wait_ss(1'b0, "f1_start");
    wait_ss(1'b1, "f1_end");
    addr = 5'd1;
    #1;
    check_output("x_old_in_update", rd_data, 32'd0);
    addr = 5'd5; wr_data = 32'd0; cs = 1'b1; write = 1'b1;
    @(posedge clk); #1;
    cs = 1'b0; write = 1'b0;
    pop_check("f1");
    apply_stimulus(5'd5, 32'd0);
    read_check("valid_cleared", 5'd0, 32'd0);
    read_check("unmapped_addr7", 5'd7, 32'd0);
    apply_stimulus(5'd1, 32'hDEAD_BEEF);
    read_check("x_ro_ignored", 5'd1, 32'h0000_1234);

    // Disable during bit 20 of the second frame.
    push_read_frame(32'd2);
    wait_ss(1'b0, "f2_start");
    n = 0;
    while (edge_cnt < 20 && spi_ss_n === 1'b0 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    check_output("f2_disable_edge", edge_cnt, 32'd20);
    apply_stimulus(5'd0, 32'd0);
    wait_ss(1'b1, "f2_end");
    @(posedge clk); #1;
    pop_check("f2");
    low_cnt = 0;
    repeat (200) begin
      @(posedge clk); #1;
      if (spi_ss_n !== 1'b1) low_cnt++;
    end
    check_output("idle_no_frames", low_cnt, 32'd0);
    read_check("idle_count", 5'd4, 32'd2);

    // Re-enable (no second init), then reset in the middle of SHIFT.
    apply_stimulus(5'd0, 32'd1);
    wait_ss(1'b0, "f3_start");
    n = 0;
    while (edge_cnt < 30 && spi_ss_n === 1'b0 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    check_output("f3_read_frame_edges", edge_cnt, 32'd30);
    reset = 1'b1;
    @(posedge clk); #1;
    check_output("abort_ss_n", {31'd0, spi_ss_n}, 32'd1);
    check_output("abort_sclk", {31'd0, spi_sclk}, 32'd0);
    read_check("abort_x", 5'd1, 32'd0);
    read_check("abort_y", 5'd2, 32'd0);
    read_check("abort_z", 5'd3, 32'd0);
    read_check("abort_count", 5'd4, 32'd0);
    read_check("abort_status", 5'd0, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Frame after the abort must be complete and correct.
`ifdef ACL_INIT_EN
    push_init_frame();
`endif
    push_read_frame(32'd1);
    apply_stimulus(5'd0, 32'd1);
`ifdef ACL_INIT_EN
    run_init_frame("f4");
`endif
    wait_ss(1'b0, "f4_start");
    wait_ss(1'b1, "f4_end");
    @(posedge clk); #1;
    pop_check("f4");
    apply_stimulus(5'd0, 32'd0);
    check_output("mosi_queue_drained", mosi_exp.size(), 32'd0);
    check_output("edge_queue_drained", edge_exp.size(), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
